// File: rtl/mem_access_stage.sv
// Memory-access stage: latches executed instructions, runs loads/stores over the
// valid/addr_ok/data_ok data bus, and registers results into the writeback slot.
module mem_access_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        M_valid,
    input  logic [5:0]  M_icode,
    input  logic [4:0]  M_dst,
    input  logic [31:0] M_val3,
    input  logic [31:0] M_valt,
    output logic        m_busy,
    output logic        m_load_pending,
    output logic [4:0]  m_dst,
    output logic [31:0] m_val3,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [2:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic        w_valid,
    output logic [4:0]  w_dst,
    output logic [31:0] w_val3
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    function automatic logic op_is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic [5:0]  icode_q, icode_d;
    logic [4:0]  dst_q, dst_d;
    logic [31:0] val3_q, val3_d;
    logic [31:0] valt_q, valt_d;
    logic        w_valid_q, w_valid_d;
    logic [4:0]  w_dst_q, w_dst_d;
    logic [31:0] w_val3_q, w_val3_d;

    logic        is_load, is_store, busy, complete, accept, new_mem;
    logic [31:0] shift_b, shift_h, load_data;

    always_comb begin
        is_load  = valid_q && op_is_load(icode_q);
        is_store = valid_q && op_is_store(icode_q);
        busy     = (state_q != IDLE);
        complete = ((state_q == REQ) && dresp_addr_ok && dresp_data_ok) ||
                   ((state_q == RESP) && dresp_data_ok);
        // The next instruction is taken on the completion edge so back-to-back
        // memory ops re-enter REQ without an idle gap.
        accept   = !busy || complete;
        new_mem  = M_valid && (op_is_load(M_icode) || op_is_store(M_icode));

        shift_b = dresp_data >> {val3_q[1:0], 3'b000};
        shift_h = dresp_data >> {val3_q[1], 4'b0000};
        case (icode_q)
            OP_LB:   load_data = {{24{shift_b[7]}}, shift_b[7:0]};
            OP_LBU:  load_data = {24'h0, shift_b[7:0]};
            OP_LH:   load_data = {{16{shift_h[15]}}, shift_h[15:0]};
            OP_LHU:  load_data = {16'h0, shift_h[15:0]};
            default: load_data = dresp_data;
        endcase

        valid_d = valid_q;
        icode_d = icode_q;
        dst_d   = dst_q;
        val3_d  = val3_q;
        valt_d  = valt_q;
        if (accept) begin
            valid_d = M_valid;
            icode_d = M_valid ? M_icode : 6'h0;
            dst_d   = M_valid ? M_dst : 5'h0;
            val3_d  = M_val3;
            valt_d  = M_valt;
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (new_mem) state_d = REQ;
            REQ:     if (complete) state_d = new_mem ? REQ : IDLE;
                     else if (dresp_addr_ok) state_d = RESP;
            RESP:    if (complete) state_d = new_mem ? REQ : IDLE;
            default: state_d = IDLE;
        endcase

        w_valid_d = 1'b0;
        w_dst_d   = 5'h0;
        w_val3_d  = 32'h0;
        if (!busy) begin
            // A memory op seen in IDLE has already written back on completion.
            if (!is_load && !is_store) begin
                w_valid_d = valid_q;
                w_dst_d   = dst_q;
                w_val3_d  = val3_q;
            end
        end else if (complete) begin
            w_valid_d = 1'b1;
            w_dst_d   = is_load ? dst_q : 5'h0;
            w_val3_d  = is_load ? load_data : val3_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            icode_q   <= 6'h0;
            dst_q     <= 5'h0;
            val3_q    <= 32'h0;
            valt_q    <= 32'h0;
            w_valid_q <= 1'b0;
            w_dst_q   <= 5'h0;
            w_val3_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            icode_q   <= icode_d;
            dst_q     <= dst_d;
            val3_q    <= val3_d;
            valt_q    <= valt_d;
            w_valid_q <= w_valid_d;
            w_dst_q   <= w_dst_d;
            w_val3_q  <= w_val3_d;
        end
    end

    always_comb begin
        m_busy         = busy;
        m_load_pending = is_load && busy;
        m_dst          = is_store ? 5'h0 : dst_q;
        m_val3         = val3_q;
        dreq_valid     = (state_q == REQ);
        dreq_addr      = val3_q;
        w_valid        = w_valid_q;
        w_dst          = w_dst_q;
        w_val3         = w_val3_q;

        dreq_size   = 3'd0;
        dreq_strobe = 4'h0;
        dreq_data   = 32'h0;
        case (icode_q)
            OP_LB, OP_LBU: dreq_size = 3'd0;
            OP_LH, OP_LHU: dreq_size = 3'd1;
            OP_LW:         dreq_size = 3'd2;
            OP_SB: begin
                dreq_size   = 3'd0;
                dreq_strobe = 4'b0001 << val3_q[1:0];
                dreq_data   = {4{valt_q[7:0]}};
            end
            OP_SH: begin
                dreq_size   = 3'd1;
                dreq_strobe = val3_q[1] ? 4'b1100 : 4'b0011;
                dreq_data   = {2{valt_q[15:0]}};
            end
            OP_SW: begin
                dreq_size   = 3'd2;
                dreq_strobe = 4'hF;
                dreq_data   = valt_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores, stalls,
// back-to-back memory ops and reset in the middle of an access.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        M_valid;
    logic [5:0]  M_icode;
    logic [4:0]  M_dst;
    logic [31:0] M_val3, M_valt;
    logic        m_busy, m_load_pending;
    logic [4:0]  m_dst;
    logic [31:0] m_val3;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;
    logic        w_valid;
    logic [4:0]  w_dst;
    logic [31:0] w_val3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .resetn(resetn),
        .M_valid(M_valid), .M_icode(M_icode), .M_dst(M_dst),
        .M_val3(M_val3), .M_valt(M_valt),
        .m_busy(m_busy), .m_load_pending(m_load_pending),
        .m_dst(m_dst), .m_val3(m_val3),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data),
        .w_valid(w_valid), .w_dst(w_dst), .w_val3(w_val3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            $display("check %-16s observed %h expected %h ok", tag, obs, exp);
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [5:0] op, input logic [4:0] dst,
                           input logic [31:0] v3, input logic [31:0] vt);
        M_valid = 1'b1;
        M_icode = op;
        M_dst   = dst;
        M_val3  = v3;
        M_valt  = vt;
    endtask

    task automatic bubble();
        M_valid = 1'b0;
        M_icode = 6'h0;
        M_dst   = 5'h0;
        M_val3  = 32'h0;
        M_valt  = 32'h0;
    endtask

    // Best-case load: addr_ok and data_ok together in the first REQ cycle.
    task automatic fast_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] word, input logic [31:0] exp);
        present(op, 5'd7, addr, 32'h0);
        tick();
        bubble();
        check({tag, "_busy"}, m_busy, 1);
        check({tag, "_pend"}, m_load_pending, 1);
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = word;
        tick();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        check({tag, "_wvalid"}, w_valid, 1);
        check({tag, "_wdst"}, w_dst, 7);
        check({tag, "_wval3"}, w_val3, exp);
        check({tag, "_idle"}, m_busy, 0);
    endtask

    initial begin
        resetn        = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = 32'h0;
        bubble();
        tick();
        tick();
        check("rst_busy", m_busy, 0);
        check("rst_dreq", dreq_valid, 0);
        check("rst_wvalid", w_valid, 0);
        check("rst_wval3", w_val3, 0);
        resetn = 1'b1;

        // ALU op passes through in one cycle
        present(6'h09, 5'd5, 32'h1234, 32'h0);
        tick();
        bubble();
        check("alu_mdst", m_dst, 5);
        check("alu_mval3", m_val3, 32'h1234);
        check("alu_busy", m_busy, 0);
        tick();
        check("alu_wvalid", w_valid, 1);
        check("alu_wdst", w_dst, 5);
        check("alu_wval3", w_val3, 32'h1234);

        fast_load("lb", 6'h20, 32'h1003, 32'h80AABBCC, 32'hFFFFFF80);
        fast_load("lbu", 6'h24, 32'h1003, 32'h80AABBCC, 32'h00000080);
        fast_load("lh", 6'h21, 32'h1002, 32'h80011234, 32'hFFFF8001);
        fast_load("lhu", 6'h25, 32'h1002, 32'h80011234, 32'h00008001);

        // SH with split addr_ok / data_ok
        present(6'h29, 5'd9, 32'h2002, 32'h0000BEEF);
        tick();
        bubble();
        check("sh_strobe", dreq_strobe, 4'b1100);
        check("sh_data", dreq_data, 32'hBEEFBEEF);
        check("sh_size", dreq_size, 1);
        check("sh_mdst", m_dst, 0);
        check("sh_pend", m_load_pending, 0);
        dresp_addr_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        check("sh_resp_busy", m_busy, 1);
        check("sh_resp_dreq", dreq_valid, 0);
        check("sh_resp_wvalid", w_valid, 0);
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        check("sh_wvalid", w_valid, 1);
        check("sh_wdst", w_dst, 0);
        check("sh_done", m_busy, 0);

        // LW: addr_ok on busy cycle 3, data_ok on busy cycle 5; SW held behind it
        present(6'h23, 5'd3, 32'h3000, 32'h0);
        tick();
        present(6'h2B, 5'd0, 32'h4004, 32'hCAFEF00D);
        dresp_data = 32'h11223344;
        for (int i = 1; i <= 5; i++) begin
            dresp_addr_ok = (i == 3);
            dresp_data_ok = (i == 5);
            check($sformatf("lw_busy%0d", i), m_busy, 1);
            check($sformatf("lw_pend%0d", i), m_load_pending, 1);
            if (i <= 3) begin
                check($sformatf("lw_dreq%0d", i), dreq_valid, 1);
                check($sformatf("lw_addr%0d", i), dreq_addr, 32'h3000);
                check($sformatf("lw_size%0d", i), dreq_size, 2);
            end else begin
                check($sformatf("lw_dreq%0d", i), dreq_valid, 0);
            end
            if (i >= 2)
                check($sformatf("lw_wbub%0d", i), w_valid, 0);
            tick();
        end
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        bubble();
        check("lw_wvalid", w_valid, 1);
        check("lw_wdst", w_dst, 3);
        check("lw_wval3", w_val3, 32'h11223344);
        check("b2b_busy", m_busy, 1);
        check("b2b_dreq", dreq_valid, 1);
        check("sw_addr", dreq_addr, 32'h4004);
        check("sw_strobe", dreq_strobe, 4'hF);
        check("sw_data", dreq_data, 32'hCAFEF00D);
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        check("sw_wvalid", w_valid, 1);
        check("sw_wdst", w_dst, 0);
        check("sw_done", m_busy, 0);

        // Reset while in RESP
        present(6'h23, 5'd6, 32'h5000, 32'h0);
        tick();
        bubble();
        dresp_addr_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        check("pre_rst_pend", m_load_pending, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("mr_busy", m_busy, 0);
        check("mr_pend", m_load_pending, 0);
        check("mr_mdst", m_dst, 0);
        check("mr_mval3", m_val3, 0);
        check("mr_dreq", dreq_valid, 0);
        check("mr_daddr", dreq_addr, 0);
        check("mr_wvalid", w_valid, 0);
        check("mr_wdst", w_dst, 0);
        check("mr_wval3", w_val3, 0);
        dresp_data_ok = 1'b1;
        tick();
        dresp_data_ok = 1'b0;
        check("late_wvalid", w_valid, 0);
        check("late_busy", m_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
